// File: rtl/stream_timing_pkg.sv
// Shared types for the stream timing decoder: FSM states and the err_status bit map.
package stream_timing_pkg;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } decState_e;

    localparam int ERR_EARLY_EOL   = 0;
    localparam int ERR_MISSING_EOL = 1;
    localparam int ERR_EARLY_SOF   = 2;
    localparam int ERR_BAD_CFG     = 3;

endpackage

// File: rtl/stream_timing_decoder.sv
// Recovers pixel position, sync levels and frame/line strobes from an AXI-Stream video
// input, with sticky framing-error flags and frame/drop counters.
module stream_timing_decoder
    import stream_timing_pkg::*;
(
    input  logic        eim_clk,
    input  logic        eim_rst,
    input  logic        enable,
    input  logic        clr_status,
    input  logic [15:0] cfg_h_count,
    input  logic [15:0] cfg_v_count,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [15:0] h_pos,
    output logic [15:0] v_pos,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic        frame_done,
    output logic [3:0]  err_status,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    decState_e   state_q, state_d;
    logic        enable_q;
    logic [15:0] hLim_q, hLim_d;
    logic [15:0] vLim_q, vLim_d;
    logic [15:0] hCnt_q, hCnt_d;
    logic [15:0] vCnt_q, vCnt_d;

    logic        pixValid_q, pixValid_d;
    logic [15:0] pixData_q, pixData_d;
    logic [15:0] hPos_q, hPos_d;
    logic [15:0] vPos_q, vPos_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        lineStart_q, lineStart_d;
    logic        frameStart_q, frameStart_d;
    logic        frameDone_q, frameDone_d;
    logic        lastPix_q, lastPix_d;
    logic [3:0]  errStatus_q, errStatus_d;
    logic [15:0] frameCnt_q, frameCnt_d;
    logic [15:0] dropCnt_q, dropCnt_d;

    logic        accept;
    logic        cfgBad;
    logic        take;
    logic        lineEnd;
    logic        frameEnd;
    logic        dropInc;
    logic [3:0]  errSet;
    logic [15:0] pixH, pixV;
    logic [15:0] hLimUse, vLimUse;
    logic [15:0] dropBase;

    assign accept = s_axis_tvalid && enable_q;
    assign cfgBad = (cfg_h_count == 16'd0) || (cfg_v_count == 16'd0);

    always_comb begin
        state_d  = state_q;
        hLim_d   = hLim_q;
        vLim_d   = vLim_q;
        hCnt_d   = hCnt_q;
        vCnt_d   = vCnt_q;
        take     = 1'b0;
        lineEnd  = 1'b0;
        frameEnd = 1'b0;
        dropInc  = 1'b0;
        errSet   = 4'd0;
        pixH     = hCnt_q;
        pixV     = vCnt_q;
        hLimUse  = hLim_q;
        vLimUse  = vLim_q;

        // Any SOF (re)latches the geometry; the SOF beat itself becomes pixel (0,0).
        if (accept) begin
            if (s_axis_tuser) begin
                if (state_q == ACTIVE && (hCnt_q != 16'd0 || vCnt_q != 16'd0))
                    errSet[ERR_EARLY_SOF] = 1'b1;
                if (cfgBad) begin
                    errSet[ERR_BAD_CFG] = 1'b1;
                    state_d = WAIT_SOF;
                    hCnt_d  = 16'd0;
                    vCnt_d  = 16'd0;
                end else begin
                    take    = 1'b1;
                    pixH    = 16'd0;
                    pixV    = 16'd0;
                    hLimUse = cfg_h_count - 16'd1;
                    vLimUse = cfg_v_count - 16'd1;
                    hLim_d  = hLimUse;
                    vLim_d  = vLimUse;
                end
            end else if (state_q == ACTIVE) begin
                take = 1'b1;
            end else begin
                dropInc = 1'b1;
            end
        end

        if (take) begin
            lineEnd = s_axis_tlast || (pixH == hLimUse);
            if (s_axis_tlast && (pixH < hLimUse))
                errSet[ERR_EARLY_EOL] = 1'b1;
            if (!s_axis_tlast && (pixH == hLimUse))
                errSet[ERR_MISSING_EOL] = 1'b1;
            if (lineEnd) begin
                hCnt_d = 16'd0;
                if (pixV == vLimUse) begin
                    frameEnd = 1'b1;
                    vCnt_d   = 16'd0;
                    state_d  = WAIT_SOF;
                end else begin
                    vCnt_d  = pixV + 16'd1;
                    state_d = ACTIVE;
                end
            end else begin
                hCnt_d  = pixH + 16'd1;
                vCnt_d  = pixV;
                state_d = ACTIVE;
            end
        end
    end

    always_comb begin
        pixValid_d   = take;
        pixData_d    = take ? s_axis_tdata : pixData_q;
        hPos_d       = take ? pixH : hPos_q;
        vPos_d       = take ? pixV : vPos_q;
        lineStart_d  = take && (pixH == 16'd0);
        frameStart_d = take && (pixH == 16'd0) && (pixV == 16'd0);
        frameDone_d  = frameEnd;
        lastPix_d    = take && lineEnd;

        // Sync levels drop one cycle after the closing strobe unless a new line/frame reopens them.
        hsync_d = lineStart_d  ? 1'b1 : (lastPix_q   ? 1'b0 : hsync_q);
        vsync_d = frameStart_d ? 1'b1 : (frameDone_q ? 1'b0 : vsync_q);

        errStatus_d = (clr_status ? 4'd0 : errStatus_q) | errSet;
        frameCnt_d  = (clr_status ? 16'd0 : frameCnt_q) + {15'd0, frameEnd};
        dropBase    = clr_status ? 16'd0 : dropCnt_q;
        dropCnt_d   = (dropInc && dropBase != 16'hFFFF) ? dropBase + 16'd1 : dropBase;
    end

    always_ff @(posedge eim_clk or posedge eim_rst) begin
        if (eim_rst) begin
            state_q      <= WAIT_SOF;
            enable_q     <= 1'b0;
            hLim_q       <= 16'd0;
            vLim_q       <= 16'd0;
            hCnt_q       <= 16'd0;
            vCnt_q       <= 16'd0;
            pixValid_q   <= 1'b0;
            pixData_q    <= 16'd0;
            hPos_q       <= 16'd0;
            vPos_q       <= 16'd0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
            frameDone_q  <= 1'b0;
            lastPix_q    <= 1'b0;
            errStatus_q  <= 4'd0;
            frameCnt_q   <= 16'd0;
            dropCnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable;
            hLim_q       <= hLim_d;
            vLim_q       <= vLim_d;
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            pixValid_q   <= pixValid_d;
            pixData_q    <= pixData_d;
            hPos_q       <= hPos_d;
            vPos_q       <= vPos_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            lineStart_q  <= lineStart_d;
            frameStart_q <= frameStart_d;
            frameDone_q  <= frameDone_d;
            lastPix_q    <= lastPix_d;
            errStatus_q  <= errStatus_d;
            frameCnt_q   <= frameCnt_d;
            dropCnt_q    <= dropCnt_d;
        end
    end

    assign s_axis_tready = enable_q;
    assign pix_valid     = pixValid_q;
    assign pix_data      = pixData_q;
    assign h_pos         = hPos_q;
    assign v_pos         = vPos_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign line_start    = lineStart_q;
    assign frame_start   = frameStart_q;
    assign frame_done    = frameDone_q;
    assign err_status    = errStatus_q;
    assign frame_cnt     = frameCnt_q;
    assign drop_cnt      = dropCnt_q;

endmodule

// File: tb/tb_stream_timing_decoder.sv
// Directed bench for stream_timing_decoder: stimulus queues expected pixels, a negedge
// monitor pops and compares them whenever pix_valid is seen.
module tb_stream_timing_decoder;

    logic        eim_clk;
    logic        eim_rst;
    logic        enable;
    logic        clr_status;
    logic [15:0] cfg_h_count;
    logic [15:0] cfg_v_count;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tuser;
    logic        s_axis_tlast;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [15:0] h_pos;
    logic [15:0] v_pos;
    logic        hsync;
    logic        vsync;
    logic        line_start;
    logic        frame_start;
    logic        frame_done;
    logic [3:0]  err_status;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] h;
        logic [15:0] v;
        logic        ls;
        logic        fs;
    } pixExp_t;

    pixExp_t expQ[$];
    int assertCount = 0;
    int failCount   = 0;
    int lineStartSeen  = 0;
    int frameStartSeen = 0;
    int frameDoneSeen  = 0;
    int beatNum = 0;
    int snapLs, snapFs, snapFd;

    stream_timing_decoder dut (
        .eim_clk       (eim_clk),
        .eim_rst       (eim_rst),
        .enable        (enable),
        .clr_status    (clr_status),
        .cfg_h_count   (cfg_h_count),
        .cfg_v_count   (cfg_v_count),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .h_pos         (h_pos),
        .v_pos         (v_pos),
        .hsync         (hsync),
        .vsync         (vsync),
        .line_start    (line_start),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .err_status    (err_status),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt)
    );

    initial eim_clk = 1'b0;
    always #5 eim_clk = ~eim_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAllZero(input string name);
        logic any;
        any = |{pix_valid, pix_data, h_pos, v_pos, hsync, vsync, line_start, frame_start,
                frame_done, err_status, frame_cnt, drop_cnt, s_axis_tready};
        checkOutput(name, {31'd0, any}, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge eim_clk);
            #1;
        end
    endtask

    task automatic pulseClear();
        clr_status = 1'b1;
        idle(1);
        clr_status = 1'b0;
    endtask

    // One beat, accepted on the next rising edge; the expected pixel is queued first.
    task automatic applyStimulus(input logic user, input logic last, input bit expPix,
                                 input int expH, input int expV);
        logic [15:0] d;
        beatNum++;
        d = 16'hA000 + beatNum[15:0];
        if (expPix)
            expQ.push_back('{data: d, h: expH[15:0], v: expV[15:0],
                             ls: (expH == 0), fs: (expH == 0 && expV == 0)});
        s_axis_tdata  = d;
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(posedge eim_clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Clean run of n beats from (h0,v0) with tlast on the last column.
    task automatic applyRun(input int n, input int hCfg, input int h0, input int v0, input bit sofFirst);
        int h = h0;
        int v = v0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(sofFirst && i == 0, h == hCfg - 1, 1'b1, h, v);
            h++;
            if (h == hCfg) begin
                h = 0;
                v++;
            end
        end
    endtask

    // Monitor: compare every presented pixel against the head of the scoreboard.
    always @(negedge eim_clk) begin
        if (!eim_rst) begin
            if (line_start)  lineStartSeen++;
            if (frame_start) frameStartSeen++;
            if (frame_done)  frameDoneSeen++;
            if (pix_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedPixel", {16'd0, h_pos}, 32'hFFFF_FFFF);
                end else begin
                    pixExp_t e;
                    e = expQ.pop_front();
                    checkOutput("pixData", {16'd0, pix_data}, {16'd0, e.data});
                    checkOutput("hPos", {16'd0, h_pos}, {16'd0, e.h});
                    checkOutput("vPos", {16'd0, v_pos}, {16'd0, e.v});
                    checkOutput("lineStart", {31'd0, line_start}, {31'd0, e.ls});
                    checkOutput("frameStart", {31'd0, frame_start}, {31'd0, e.fs});
                    checkOutput("hsyncOnPix", {31'd0, hsync}, 32'd1);
                    checkOutput("vsyncOnPix", {31'd0, vsync}, 32'd1);
                end
            end else begin
                checkOutput("strobeWithoutPix", {30'd0, line_start, frame_start}, 32'd0);
            end
        end
    end

    initial begin
        eim_rst       = 1'b1;
        enable        = 1'b0;
        clr_status    = 1'b0;
        cfg_h_count   = 16'd8;
        cfg_v_count   = 16'd4;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 16'd0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        idle(3);
        checkAllZero("resetOutputs");
        eim_rst = 1'b0;
        enable  = 1'b1;
        idle(2);
        checkOutput("treadyFollowsEnable", {31'd0, s_axis_tready}, 32'd1);

        $display("[TB] drops and bad config");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
        checkOutput("dropCnt5", {16'd0, drop_cnt}, 32'd5);
        cfg_h_count = 16'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        checkOutput("errBadCfg", {28'd0, err_status}, 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
        checkOutput("stillWaitSof", {16'd0, drop_cnt}, 32'd6);
        cfg_h_count = 16'd8;
        pulseClear();
        checkOutput("clrErr", {28'd0, err_status}, 32'd0);
        checkOutput("clrDrop", {16'd0, drop_cnt}, 32'd0);

        $display("[TB] normal frames");
        snapLs = lineStartSeen;
        snapFd = frameDoneSeen;
        applyRun(32, 8, 0, 0, 1'b1);
        idle(2);
        checkOutput("vsyncLowBetween", {31'd0, vsync}, 32'd0);
        checkOutput("hsyncLowBetween", {31'd0, hsync}, 32'd0);
        applyRun(32, 8, 0, 0, 1'b1);
        idle(3);
        checkOutput("frameCnt2", {16'd0, frame_cnt}, 32'd2);
        checkOutput("errClean", {28'd0, err_status}, 32'd0);
        checkOutput("lineStarts8", lineStartSeen - snapLs, 32'd8);
        checkOutput("frameDone2", frameDoneSeen - snapFd, 32'd2);

        $display("[TB] line length errors");
        pulseClear();
        applyRun(8, 8, 0, 0, 1'b1);
        for (int h = 0; h < 5; h++) applyStimulus(1'b0, h == 4, 1'b1, h, 1);
        checkOutput("errEarlyEol", {28'd0, err_status}, 32'h1);
        for (int h = 0; h < 8; h++) applyStimulus(1'b0, 1'b0, 1'b1, h, 2);
        checkOutput("errMissingEol", {28'd0, err_status}, 32'h3);
        applyRun(8, 8, 0, 3, 1'b0);
        idle(2);
        checkOutput("frameCntAfterErr", {16'd0, frame_cnt}, 32'd1);

        $display("[TB] early SOF");
        pulseClear();
        snapFs = frameStartSeen;
        applyRun(19, 8, 0, 0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 0, 0);
        checkOutput("errEarlySof", {28'd0, err_status}, 32'h4);
        checkOutput("vsyncStaysHigh", {31'd0, vsync}, 32'd1);
        applyRun(31, 8, 1, 0, 1'b0);
        idle(3);
        checkOutput("frameStartTwice", frameStartSeen - snapFs, 32'd2);
        checkOutput("frameCntEarlySof", {16'd0, frame_cnt}, 32'd1);

        $display("[TB] backpressure");
        applyRun(4, 8, 0, 0, 1'b1);
        enable = 1'b0;
        idle(1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'hDEAD;
        for (int i = 0; i < 10; i++) begin
            checkOutput("treadyLow", {31'd0, s_axis_tready}, 32'd0);
            checkOutput("hFrozen", {16'd0, h_pos}, 32'd3);
            checkOutput("vFrozen", {16'd0, v_pos}, 32'd0);
            checkOutput("hsyncHeld", {31'd0, hsync}, 32'd1);
            checkOutput("vsyncHeld", {31'd0, vsync}, 32'd1);
            idle(1);
        end
        s_axis_tvalid = 1'b0;
        enable = 1'b1;
        idle(1);
        applyRun(28, 8, 4, 0, 1'b0);
        idle(2);
        checkOutput("frameCntBackpressure", {16'd0, frame_cnt}, 32'd2);

        $display("[TB] reset mid-frame");
        applyRun(8, 8, 0, 0, 1'b1);
        applyRun(4, 8, 0, 1, 1'b0);
        @(negedge eim_clk);
        #1;
        checkOutput("queueDrainedBeforeReset", expQ.size(), 32'd0);
        snapFd = frameDoneSeen;
        eim_rst = 1'b1;
        #1;
        checkAllZero("midFrameResetOutputs");
        idle(3);
        eim_rst = 1'b0;
        idle(4);
        checkOutput("noFrameDoneOnReset", frameDoneSeen - snapFd, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
        checkOutput("needsNewSof", {16'd0, drop_cnt}, 32'd1);

        $display("[TB] one-pixel lines");
        cfg_h_count = 16'd1;
        cfg_v_count = 16'd2;
        snapFd = frameDoneSeen;
        applyStimulus(1'b1, 1'b1, 1'b1, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 0, 1);
        idle(2);
        checkOutput("onePixFrameDone", frameDoneSeen - snapFd, 32'd1);
        checkOutput("onePixNoErr", {28'd0, err_status}, 32'd0);
        checkOutput("onePixFrameCnt", {16'd0, frame_cnt}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
        checkOutput("onePixBackToWait", {16'd0, drop_cnt}, 32'd2);

        idle(3);
        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
